// File: rtl/melody_pkg.sv
// ============================================================================
// Module      : melody_pkg
// Description : Note codes, frequency table, sequencer states and the
//               half-period constant function for melody_player.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package melody_pkg;

  // Note codes held in the low nibble of a ROM entry
  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_CS4  = 4'd2;
  localparam logic [3:0] NOTE_D4   = 4'd3;
  localparam logic [3:0] NOTE_DS4  = 4'd4;
  localparam logic [3:0] NOTE_E4   = 4'd5;
  localparam logic [3:0] NOTE_F4   = 4'd6;
  localparam logic [3:0] NOTE_FS4  = 4'd7;
  localparam logic [3:0] NOTE_G4   = 4'd8;
  localparam logic [3:0] NOTE_GS4  = 4'd9;
  localparam logic [3:0] NOTE_A4   = 4'd10;
  localparam logic [3:0] NOTE_AS4  = 4'd11;
  localparam logic [3:0] NOTE_B4   = 4'd12;
  localparam logic [3:0] NOTE_C5   = 4'd13;
  localparam logic [3:0] NOTE_CS5  = 4'd14;
  localparam logic [3:0] NOTE_D5   = 4'd15;

  // Integer frequencies in Hz for codes 1..15 (C4..D5)
  localparam logic [15:1][9:0] FREQ_HZ = {
    10'd587, 10'd554, 10'd523, 10'd494, 10'd466,
    10'd440, 10'd415, 10'd392, 10'd370, 10'd349,
    10'd330, 10'd311, 10'd294, 10'd277, 10'd262
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Tone half-period in clock cycles; a rest has no tone and returns 0
  function automatic int half_period(input int clk_hz, input logic [3:0] code);
    if (code == NOTE_REST) begin
      return 0;
    end
    return clk_hz / (2 * int'(FREQ_HZ[code]));
  endfunction

endpackage

`default_nettype wire

// File: rtl/melody_rom.sv
// ============================================================================
// Module      : melody_rom
// Description : Combinational melody table, NUM_NOTES entries of
//               {dur[1:0], code[3:0]}. Swap the table to change the tune.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module melody_rom
  import melody_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  localparam int IDX_W = $clog2(NUM_NOTES)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [5:0]       entry
);

  logic [5:0] addr;

  // Table lookup; addresses past the melody read as a short rest
  always_comb begin
    addr  = 6'(idx);
    entry = {2'd0, NOTE_REST};
    if (int'(addr) < NUM_NOTES) begin
      case (addr)
        6'd0:    entry = {2'd0, NOTE_A4};
        6'd1:    entry = {2'd0, NOTE_REST};
        6'd2:    entry = {2'd1, NOTE_C5};
        6'd3:    entry = {2'd0, NOTE_A4};
        6'd4:    entry = {2'd0, NOTE_E4};
        6'd5:    entry = {2'd0, NOTE_A4};
        6'd6:    entry = {2'd0, NOTE_C5};
        6'd7:    entry = {2'd1, NOTE_D5};
        6'd8:    entry = {2'd0, NOTE_C5};
        6'd9:    entry = {2'd0, NOTE_B4};
        6'd10:   entry = {2'd0, NOTE_A4};
        6'd11:   entry = {2'd0, NOTE_G4};
        6'd12:   entry = {2'd1, NOTE_A4};
        6'd13:   entry = {2'd0, NOTE_REST};
        6'd14:   entry = {2'd0, NOTE_E4};
        6'd15:   entry = {2'd3, NOTE_A4};
        default: entry = {2'd0, NOTE_REST};
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/melody_player.sv
// ============================================================================
// Module      : melody_player
// Description : Square-wave alarm melody sequencer. Plays the melody_rom
//               table note by note with a silent gap after each note,
//               optionally looping. Single clock domain, no derived clocks.
//               Optional build macro MELODY_VOLUME_EN adds a 3-bit volume
//               input that gates the high half-cycles with an 8-step carrier.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module melody_player
  import melody_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int NUM_NOTES = 16,
  parameter int TEMPO_MS  = 125,
  parameter int GAP_MS    = 20,
  localparam int IDX_W    = $clog2(NUM_NOTES)
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             enable,
  input  logic             loop,
`ifdef MELODY_VOLUME_EN
  input  logic [2:0]       volume,
`endif
  output logic             AUD_PWM,
  output logic             AUD_SD,
  output logic             busy,
  output logic [IDX_W-1:0] note_idx
);

  localparam int MS_CYC = CLK_HZ / 1000;
  localparam int PRE_W  = $clog2(MS_CYC);
  localparam int HP_W   = $clog2(half_period(CLK_HZ, NOTE_C4));
  localparam int DUR_W  = $clog2(4 * TEMPO_MS + GAP_MS + 1);

  state_t           state, next_state;
  logic [PRE_W-1:0] presc;
  logic [DUR_W-1:0] dur_cnt;
  logic [HP_W-1:0]  tone_cnt;
  logic             tone_hi;
  logic [5:0]       entry;
  logic [1:0]       dur;
  logic [3:0]       code;
  logic             ms_tick, note_load, gap_enter, restart;
  logic             idx_inc, idx_clr, vol_ok;
  logic [HP_W-1:0]  half_tab [16];

  // Half-period per note code, fixed at elaboration
  for (genvar c = 0; c < 16; c++) begin : g_half_tab
    assign half_tab[c] = HP_W'(half_period(CLK_HZ, 4'(c)));
  end

  melody_rom #(.NUM_NOTES(NUM_NOTES)) u_rom (
    .idx   (note_idx),
    .entry (entry)
  );

  assign dur     = entry[5:4];
  assign code    = entry[3:0];
  assign ms_tick = (int'(presc) == MS_CYC - 1);
  assign restart = note_load | gap_enter | ~enable;

  // Next-state logic; a low enable overrides every transition
  always_comb begin
    next_state = state;
    note_load  = 1'b0;
    gap_enter  = 1'b0;
    idx_inc    = 1'b0;
    idx_clr    = 1'b0;
    if (!enable) begin
      next_state = IDLE;
      idx_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          next_state = PLAY;
          note_load  = 1'b1;
          idx_clr    = 1'b1;
        end
        PLAY: begin
          if (ms_tick && int'(dur_cnt) == (int'(dur) + 1) * TEMPO_MS - 1) begin
            next_state = GAP;
            gap_enter  = 1'b1;
          end
        end
        GAP: begin
          if (ms_tick && int'(dur_cnt) == GAP_MS - 1) begin
            if (int'(note_idx) < NUM_NOTES - 1) begin
              next_state = PLAY;
              note_load  = 1'b1;
              idx_inc    = 1'b1;
            end else if (loop) begin
              next_state = PLAY;
              note_load  = 1'b1;
              idx_clr    = 1'b1;
            end else begin
              next_state = DONE;
            end
          end
        end
        default: next_state = state;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Current ROM index
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset)        note_idx <= '0;
    else if (idx_clr) note_idx <= '0;
    else if (idx_inc) note_idx <= note_idx + IDX_W'(1);
  end

  // ms prescaler and ms-tick duration counter, both restarted at phase boundaries
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      dur_cnt <= '0;
    end else if (restart) begin
      presc   <= '0;
      dur_cnt <= '0;
    end else if (ms_tick) begin
      presc   <= '0;
      dur_cnt <= dur_cnt + DUR_W'(1);
    end else begin
      presc   <= presc + PRE_W'(1);
    end
  end

  // Tone divider; runs only inside PLAY on a pitched note, low otherwise
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      tone_hi  <= 1'b0;
    end else if (restart || state != PLAY || code == NOTE_REST) begin
      tone_cnt <= '0;
      tone_hi  <= 1'b0;
    end else if (int'(tone_cnt) == int'(half_tab[code]) - 1) begin
      tone_cnt <= '0;
      tone_hi  <= ~tone_hi;
    end else begin
      tone_cnt <= tone_cnt + HP_W'(1);
    end
  end

`ifdef MELODY_VOLUME_EN
  logic [2:0] carrier;

  // Free-running carrier that sets the duty of the high half-cycles
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) carrier <= 3'd0;
    else       carrier <= carrier + 3'd1;
  end

  assign vol_ok = (carrier <= volume);
`else
  assign vol_ok = 1'b1;
`endif

  // Output stage; cleared on the edge that leaves PLAY so gaps and stops are silent
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) AUD_PWM <= 1'b0;
    else       AUD_PWM <= (next_state == PLAY) & tone_hi & vol_ok;
  end

  assign AUD_SD = (state == PLAY) || (state == GAP);
  assign busy   = AUD_SD;

endmodule

`default_nettype wire

// File: tb/tb_melody_player.sv
// ============================================================================
// Module      : tb_melody_player
// Description : Self-checking bench for melody_player at 1 MHz, 4 notes.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_melody_player;

  localparam int CLK_HZ   = 1_000_000;
  localparam int NOTES    = 4;
  localparam int TEMPO    = 4;
  localparam int GAPMS    = 1;
  localparam int MS       = CLK_HZ / 1000;
  localparam int GAP_CYC  = GAPMS * MS;

  localparam int PH_IDLE = 0, PH_PLAY = 1, PH_GAP = 2, PH_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       loop = 1'b0;
  logic       aud_pwm, aud_sd, busy;
  logic [1:0] note_idx;

  int vectors = 0;
  int miscompares = 0;

  // Melody as the bench understands it: codes and durations
  int code_tab [NOTES] = '{10, 0, 13, 10};
  int dur_tab  [NOTES] = '{0, 0, 1, 0};

  int m_ph = PH_IDLE;
  int m_idx = 0;
  int m_t = 0;

  melody_player #(
    .CLK_HZ(CLK_HZ), .NUM_NOTES(NOTES), .TEMPO_MS(TEMPO), .GAP_MS(GAPMS)
  ) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .enable    (enable),
    .loop      (loop),
`ifdef MELODY_VOLUME_EN
    .volume    (3'd7),
`endif
    .AUD_PWM   (aud_pwm),
    .AUD_SD    (aud_sd),
    .busy      (busy),
    .note_idx  (note_idx)
  );

  always #5 clk = ~clk;

  function automatic int freq(input int code);
    case (code)
      10:      return 440;
      13:      return 523;
      default: return 0;
    endcase
  endfunction

  function automatic int play_cycles(input int idx);
    return (dur_tab[idx] + 1) * TEMPO * MS;
  endfunction

  // Square wave seen t cycles into a note: one register stage behind the divider
  function automatic logic exp_pwm(input int ph, input int idx, input int t);
    int f;
    f = freq(code_tab[idx]);
    if (ph != PH_PLAY || f == 0 || t < 1) return 1'b0;
    return (((t - 1) / (CLK_HZ / (2 * f))) % 2) == 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Phase-level model: phase, note and cycles elapsed in the phase
  always @(posedge clk or posedge reset) begin
    if (reset || !enable) begin
      m_ph <= PH_IDLE; m_idx <= 0; m_t <= 0;
    end else begin
      case (m_ph)
        PH_IDLE: begin m_ph <= PH_PLAY; m_idx <= 0; m_t <= 0; end
        PH_PLAY: begin
          if (m_t + 1 == play_cycles(m_idx)) begin m_ph <= PH_GAP; m_t <= 0; end
          else m_t <= m_t + 1;
        end
        PH_GAP: begin
          if (m_t + 1 == GAP_CYC) begin
            m_t <= 0;
            if (m_idx < NOTES - 1) begin m_idx <= m_idx + 1; m_ph <= PH_PLAY; end
            else if (loop) begin m_idx <= 0; m_ph <= PH_PLAY; end
            else m_ph <= PH_DONE;
          end else m_t <= m_t + 1;
        end
        default: m_ph <= m_ph;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    check("sd",   int'(aud_sd),   int'(m_ph == PH_PLAY || m_ph == PH_GAP));
    check("busy", int'(busy),     int'(m_ph == PH_PLAY || m_ph == PH_GAP));
    check("idx",  int'(note_idx), m_idx);
    check("pwm",  int'(aud_pwm),  int'(exp_pwm(m_ph, m_idx, m_t)));
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    wait_edges(3);
    reset = 1'b0;
    wait_edges(100);
    check("reset_sd", int'(aud_sd), 0);
    check("reset_pwm", int'(aud_pwm), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_idx", int'(note_idx), 0);

    // First pass, no loop
    enable = 1'b1;
    wait_edges(1);
    check("start_sd", int'(aud_sd), 1);
    check("start_busy", int'(busy), 1);
    wait_edges(1136); check("pwm_1136", int'(aud_pwm), 0);
    wait_edges(1);    check("pwm_1137", int'(aud_pwm), 1);
    wait_edges(1135); check("pwm_2272", int'(aud_pwm), 1);
    wait_edges(1);    check("pwm_2273", int'(aud_pwm), 0);
    wait_edges(1136); check("pwm_3409", int'(aud_pwm), 1);
    wait_edges(591);
    check("gap0_sd", int'(aud_sd), 1);
    check("gap0_pwm", int'(aud_pwm), 0);
    wait_edges(1000); check("note1_idx", int'(note_idx), 1);
    wait_edges(5000); check("note2_idx", int'(note_idx), 2);
    wait_edges(956);  check("c5_pwm_956", int'(aud_pwm), 0);
    wait_edges(1);    check("c5_pwm_957", int'(aud_pwm), 1);
    wait_edges(9043); check("note3_idx", int'(note_idx), 3);
    wait_edges(4000);
    check("done_sd", int'(aud_sd), 0);
    check("done_busy", int'(busy), 0);
    wait_edges(300);  check("no_retrigger", int'(aud_sd), 0);

    // Release and restart with looping
    enable = 1'b0;
    wait_edges(1);    check("release_idx", int'(note_idx), 0);
    loop = 1'b1; enable = 1'b1;
    wait_edges(1);    check("restart_sd", int'(aud_sd), 1);
    wait_edges(23999);
    check("last_gap_idx", int'(note_idx), 3);
    check("last_gap_busy", int'(busy), 1);
    wait_edges(1);
    check("wrap_idx", int'(note_idx), 0);
    check("wrap_busy", int'(busy), 1);
    wait_edges(2000); check("mid_play_pwm", int'(aud_pwm), 1);

    // Stop mid-PLAY
    enable = 1'b0;
    wait_edges(1);
    check("stop_sd", int'(aud_sd), 0);
    check("stop_pwm", int'(aud_pwm), 0);
    check("stop_idx", int'(note_idx), 0);

    // Reset mid-GAP
    loop = 1'b0; enable = 1'b1;
    wait_edges(4501);
    check("pre_reset_sd", int'(aud_sd), 1);
    reset = 1'b1;
    #1;
    check("async_sd", int'(aud_sd), 0);
    check("async_pwm", int'(aud_pwm), 0);
    check("async_busy", int'(busy), 0);
    check("async_idx", int'(note_idx), 0);
    enable = 1'b0;
    wait_edges(3);
    reset = 1'b0;
    wait_edges(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/melody_player.md
# melody_player

Parametrised alarm-tone generator for the Nexys A7 alarm clock. It plays a fixed melody from a small note ROM as a square wave on the mono audio output, gated by `enable`, with optional looping. It replaces the single fixed-pitch tone source. Unlike that source, it runs all dividers in the one `CLK100MHZ` domain; no derived clocks are generated.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; all half-periods and ms ticks derive from it.
- `NUM_NOTES`, 16, melody length in ROM entries (2..64).
- `TEMPO_MS`, 125, duration of one note unit in ms.
- `GAP_MS`, 20, silence inserted after every note in ms.
- `CLK100MHZ`  input  1  system clock, all logic on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `enable`  input  1  high requests playback; low stops within one cycle.
- `loop`  input  1  sampled at melody end; high wraps to note 0.
- `AUD_PWM`  output  1  square-wave audio drive.
- `AUD_SD`  output  1  amplifier enable (high = amplifier on).
- `busy`  output  1  high in PLAY or GAP.
- `note_idx`  output  $clog2(NUM_NOTES)  index of the current ROM entry.

## Operation
- Reset values: state IDLE; `AUD_PWM`=0, `AUD_SD`=0, `busy`=0, `note_idx`=0. All counters are 0.
- ROM entry is 6 bits: `{dur[1:0], code[3:0]}`.
  - `code` 0 = rest; codes 1..12 = C4..B4; codes 13..15 = C5..D5.
  - Note length is (dur+1)*TEMPO_MS ms.
- Half-period per code: `CLK_HZ/(2*f_hz)`, truncated, computed at elaboration. Divider width = $clog2 of the C4 value (18 bits at 100 MHz).
- FSM:
  - IDLE: `enable`=1 → PLAY. Load entry 0; clear ms prescaler, duration counter and tone counter.
  - PLAY: the tone counter counts to half-period-1, then wraps and toggles `tone_hi`. `tone_hi` starts at 0 at every note load. For a rest, `tone_hi` is held at 0. After (dur+1)*TEMPO_MS ms ticks → GAP.
  - GAP: `tone_hi` is 0. After GAP_MS ms ticks:
    - if `note_idx` < NUM_NOTES-1: increment `note_idx`, load the next entry → PLAY;
    - else if `loop`=1: `note_idx` = 0 → PLAY;
    - else → DONE.
  - DONE: `AUD_SD`=0, `busy`=0. Stays in DONE until `enable`=0, then → IDLE. This prevents a retrigger without releasing `enable`.
  - Any state: `enable`=0 → IDLE on the next edge. `note_idx` is cleared and `AUD_PWM`/`AUD_SD` are 0 from that edge.
- Outputs:
  - `AUD_SD` = 1 exactly in PLAY and GAP.
  - `AUD_PWM` = registered `tone_hi`.
- ms tick: a prescaler counts CLK_HZ/1000 cycles. It restarts on every note load and every GAP entry, so durations are exact multiples.

## Timing
- Start latency: `enable` sampled high in IDLE → `AUD_SD`=1 and `busy`=1 after that edge (1 cycle).
- First `AUD_PWM` rise: half-period+1 cycles after PLAY entry (one register stage). Full period = 2×half-period cycles.
- PLAY lasts exactly (dur+1)*TEMPO_MS*CLK_HZ/1000 cycles. GAP lasts exactly GAP_MS*CLK_HZ/1000 cycles.
- GAP→PLAY and loop wrap take zero extra cycles.
- Reset mid-note: outputs are 0 immediately (asynchronous).
- `enable` dropping in the same cycle as a GAP expiry: the stop wins.

## Configuration
- `MELODY_VOLUME_EN` defined:
  - adds input `volume` [2:0] and a free-running 3-bit carrier counter;
  - `AUD_PWM` = `tone_hi` && (carrier ≤ `volume`), giving duty (volume+1)/8 during high half-cycles;
  - `volume`=7 is identical to the non-volume build.
- `MELODY_VOLUME_EN` undefined: no `volume` port, no carrier; `AUD_PWM` = `tone_hi`.

## Structure
- Package `melody_pkg` holds:
  - note-code localparams and the 15-entry frequency table in Hz;
  - the state encoding (IDLE, PLAY, GAP, DONE);
  - the half-period constant function `half_period(clk_hz, code)`.
- Sub-module `melody_rom`: a combinational case table, NUM_NOTES × 6 bits, indexed by `note_idx`. It is kept separate so the melody can be swapped without touching the sequencer.

## Test plan
Bench parameters: CLK_HZ=1_000_000, TEMPO_MS=4, GAP_MS=1, NUM_NOTES=4. ROM = {A4 dur0, rest dur0, C5 dur1, A4 dur0}. At these values 1 ms = 1000 cycles and the A4 half-period is 1136.
- Reset asserted then released → all outputs 0, state IDLE, for 100 cycles with `enable`=0.
- `enable`↑ → `AUD_SD`=1 after 1 cycle. `AUD_PWM` toggles at +1137, +2273, +3409. PLAY lasts 4000 cycles, then 1000 GAP cycles with `AUD_PWM`=0.
- Note 1 (rest) → `AUD_SD`=1 and `AUD_PWM`=0 for 4000 cycles. Note 2 (C5, half-period 956) lasts 8000 cycles.
- `loop`=0 at the end → DONE, `AUD_SD`=0. Holding `enable`=1 causes no retrigger; `enable`↓↑ restarts at `note_idx`=0.
- `loop`=1 → after the note 3 gap, `note_idx`=0 and PLAY with no idle cycle.
- `enable`↓ mid-PLAY, then separately `reset`↑ mid-GAP → outputs 0 (next edge / immediately), `note_idx`=0.
